layer_output_sequencer: RTL and testbench
=========================================

Name: layer_output_sequencer

Overview:
- Sits between two fully-connected layers.
- Captures the NN parallel neuron results of one layer when they complete together, then serialises them one word per cycle into the next layer's single `x_in`/`x_valid` input stream.
- Supports downstream stall, back-to-back frames, and sticky error flags for overrun and partial-valid conditions.

Parameters:
- NN, 16, number of neurons in the upstream layer (words per frame); legal range 2..64
- dataWidth, 16, width of one neuron output word
- cntWidth, 16, width of the completed-frame counter

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- o_valid  input  NN  per-neuron output valid from upstream layer
- x_out  input  NN*dataWidth  packed upstream outputs; neuron k at `[k*dataWidth +: dataWidth]`
- next_ready  input  1  downstream may accept a word this cycle
- clear_err  input  1  clears `overrun` and `sync_err`
- x_in_next  output  dataWidth  serial word to downstream layer
- x_valid_next  output  1  `x_in_next` valid this cycle
- last  output  1  current word is word NN-1 of the frame
- busy  output  1  a frame is being emitted (state SHIFT)
- overrun  output  1  sticky: a frame arrived while one was pending and was dropped
- sync_err  output  1  sticky: `o_valid` was neither all-zero nor all-one
- frame_cnt  output  cntWidth  completed frames, wraps modulo 2^cntWidth

Behaviour:
- Reset (synchronous, rst=1 at a rising edge) sets all of the following; it aborts a frame in flight, with no `last` emitted:
  - state=IDLE, idx=0, buffer=0
  - overrun=0, sync_err=0, frame_cnt=0
- Capture trigger `cap = &o_valid`. Partial condition `part = |o_valid & ~&o_valid`.
- State IDLE:
  - busy=0, x_valid_next=0.
  - On cap: buffer<=x_out, idx<=0, state<=SHIFT.
- State SHIFT:
  - busy=1.
  - x_valid_next = next_ready.
  - x_in_next = buffer word idx.
  - last = x_valid_next & (idx==NN-1).
- Combinational outputs:
  - `x_in_next` shows word idx in SHIFT and is 0 in IDLE.
  - `x_valid_next` and `last` are 0 whenever state≠SHIFT.
- Advance: when x_valid_next=1 and idx<NN-1, idx<=idx+1. When next_ready=0, idx and buffer hold.
- Frame end: when last=1:
  - frame_cnt<=frame_cnt+1 (wraps).
  - If cap is asserted the same cycle: buffer<=x_out, idx<=0, stay in SHIFT (back-to-back, no bubble, no overrun).
  - Otherwise state<=IDLE.
- Latency: cap in cycle T → word 0 presented in cycle T+1 (valid if next_ready). An uninterrupted frame occupies cycles T+1..T+NN.
- Overrun: cap in SHIFT other than on a last cycle → frame dropped, buffer untouched, overrun<=1.
- sync_err: part in any state → sync_err<=1. No capture occurs on part.
- clear_err=1 clears both sticky flags. A set condition in the same cycle wins (flag stays 1).
- idx width is clog2(NN). Buffer is written only on accepted capture.

Test Plan:
- Basic frame (NN=4, dataWidth=16 override): reset, next_ready=1; pulse o_valid=4'hF with words 0x0011,0x0022,0x0033,0x0044 (neuron 0 first) → x_valid_next high cycles T+1..T+4 with 0x0011,0x0022,0x0033,0x0044; last only at T+4; frame_cnt=1; busy falls at T+5.
- Stall: same frame, next_ready=0 during cycles T+2..T+3 → x_valid_next low and idx holds at 1; sequence resumes 0x0022,0x0033,0x0044 with no word lost or duplicated; last on the 4th valid word.
- Back-to-back: second o_valid=4'hF (words 0x0A..0x0D) coincides with last of the first frame → 0x0A appears the next cycle; 8 consecutive valid words; overrun=0; frame_cnt=2.
- Overrun: second o_valid=4'hF at T+2 (mid-frame) → first frame completes unchanged; overrun=1; frame_cnt=1; state IDLE afterwards. Assert clear_err → overrun=0.
- Partial valid: o_valid=4'b0101 in IDLE → sync_err=1, no x_valid_next, state IDLE. clear_err together with another o_valid=4'b0011 → sync_err remains 1.
- Reset mid-frame: rst=1 at T+2 → next cycle x_valid_next=0, busy=0, frame_cnt=0, no last. A following full frame emits correctly from word 0.

Source files
------------

// File: rtl/layer_output_sequencer.sv
// layer_output_sequencer
//
// Sits between two fully-connected layers. When all NN neurons of the
// upstream layer report valid in the same cycle, their outputs are captured
// into a local buffer. The buffer is then streamed one word per cycle into
// the downstream layer's single x_in/x_valid input.
//
// The downstream layer can stall the stream, and a new frame can be captured
// on the same cycle the last word of the previous frame goes out, so frames
// follow each other with no bubble. Two sticky flags report frames dropped
// while one was still pending, and o_valid patterns that were neither all
// zero nor all one.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   o_valid      per-neuron valid from the upstream layer (NN bits)
//   x_out        packed upstream outputs, neuron k at [k*dataWidth +: dataWidth]
//   next_ready   downstream accepts a word this cycle
//   clear_err    clears overrun and sync_err
//   x_in_next    serial word to the downstream layer
//   x_valid_next x_in_next is valid this cycle
//   last         current word is word NN-1 of the frame
//   busy         a frame is being emitted
//   overrun      sticky: a frame arrived while one was pending and was dropped
//   sync_err     sticky: o_valid was partially set
//   frame_cnt    completed frames, wraps modulo 2^cntWidth

module layer_output_sequencer #(
  parameter int NN        = 16,
  parameter int dataWidth = 16,
  parameter int cntWidth  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           o_valid,
  input  logic [NN*dataWidth-1:0] x_out,
  input  logic                    next_ready,
  input  logic                    clear_err,
  output logic [dataWidth-1:0]    x_in_next,
  output logic                    x_valid_next,
  output logic                    last,
  output logic                    busy,
  output logic                    overrun,
  output logic                    sync_err,
  output logic [cntWidth-1:0]     frame_cnt
);

  localparam int IDX_W = $clog2(NN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_next;
  logic [dataWidth-1:0] buffer [NN];

  logic cap;
  logic part;
  logic load;
  logic overrun_set;

  // A capture needs every neuron valid at once; any other non-zero pattern
  // means the upstream neurons drifted out of lockstep.
  assign cap  = &o_valid;
  assign part = (|o_valid) & ~(&o_valid);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output logic. A capture is accepted either from IDLE or
  // on the cycle the final word of the current frame is handed downstream;
  // that second case is what lets frames run back to back.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    load         = 1'b0;
    busy         = 1'b0;
    x_valid_next = 1'b0;
    last         = 1'b0;
    x_in_next    = '0;
    overrun_set  = 1'b0;

    case (state)
      IDLE: begin
        if (cap) begin
          load       = 1'b1;
          idx_next   = '0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        busy         = 1'b1;
        x_valid_next = next_ready;
        x_in_next    = buffer[idx];
        last         = next_ready & (idx == IDX_LAST);

        if (last) begin
          if (cap) begin
            load     = 1'b1;
            idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          overrun_set = cap;
          if (next_ready) begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Word index and frame buffer. The buffer only changes on an accepted
  // capture, so a dropped frame never corrupts the one being emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      for (int k = 0; k < NN; k++) begin
        buffer[k] <= '0;
      end
    end else begin
      idx <= idx_next;
      if (load) begin
        for (int k = 0; k < NN; k++) begin
          buffer[k] <= x_out[k*dataWidth +: dataWidth];
        end
      end
    end
  end

  // Sticky error flags and the completed-frame counter. A flag condition
  // occurring in the same cycle as clear_err keeps the flag set, so no
  // event is ever lost to a concurrent clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      sync_err  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end

      if (part) begin
        sync_err <= 1'b1;
      end else if (clear_err) begin
        sync_err <= 1'b0;
      end

      if (last) begin
        frame_cnt <= frame_cnt + cntWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_layer_output_sequencer.sv
// tb_layer_output_sequencer
//
// Drives layer_output_sequencer (NN=4, dataWidth=16) through the directed
// scenarios of interest followed by a randomized phase. Expected outputs
// come from a reference model that tracks the pending frame as a queue of
// words still to be sent, plus a completed-frame count and the two flags.

module tb_layer_output_sequencer;

  localparam int NN = 4;
  localparam int DW = 16;
  localparam int CW = 16;

  logic              clk;
  logic              rst;
  logic [NN-1:0]     o_valid;
  logic [NN*DW-1:0]  x_out;
  logic              next_ready;
  logic              clear_err;
  logic [DW-1:0]     x_in_next;
  logic              x_valid_next;
  logic              last;
  logic              busy;
  logic              overrun;
  logic              sync_err;
  logic [CW-1:0]     frame_cnt;

  int compared;
  int mismatched;

  // Reference model: words still to emit for the pending frame.
  logic [DW-1:0] m_q [$];
  bit            m_active;
  bit            m_overrun;
  bit            m_sync;
  logic [CW-1:0] m_cnt;

  layer_output_sequencer #(
    .NN(NN),
    .dataWidth(DW),
    .cntWidth(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .o_valid(o_valid),
    .x_out(x_out),
    .next_ready(next_ready),
    .clear_err(clear_err),
    .x_in_next(x_in_next),
    .x_valid_next(x_valid_next),
    .last(last),
    .busy(busy),
    .overrun(overrun),
    .sync_err(sync_err),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NN*DW-1:0] pack4(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                             input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active  = 1'b0;
    m_overrun = 1'b0;
    m_sync    = 1'b0;
    m_cnt     = '0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model just before the
  // rising edge, then advance the model with the same inputs.
  task automatic apply_stimulus(input logic [NN-1:0] ov, input logic [NN*DW-1:0] xo,
                                input logic nr, input logic clr, input logic r,
                                input string tag);
    bit            e_valid;
    bit            e_last;
    logic [DW-1:0] e_word;
    bit            c;
    bit            p;

    o_valid    = ov;
    x_out      = xo;
    next_ready = nr;
    clear_err  = clr;
    rst        = r;
    #1;

    e_valid = m_active && nr;
    e_word  = m_active ? m_q[0] : '0;
    e_last  = e_valid && (m_q.size() == 1);

    check_output({tag, ".busy"},   32'(busy),         32'(m_active));
    check_output({tag, ".valid"},  32'(x_valid_next), 32'(e_valid));
    check_output({tag, ".word"},   32'(x_in_next),    32'(e_word));
    check_output({tag, ".last"},   32'(last),         32'(e_last));
    check_output({tag, ".ovr"},    32'(overrun),      32'(m_overrun));
    check_output({tag, ".sync"},   32'(sync_err),     32'(m_sync));
    check_output({tag, ".cnt"},    32'(frame_cnt),    32'(m_cnt));

    @(posedge clk);

    c = &ov;
    p = (|ov) && !(&ov);
    if (r) begin
      model_reset();
    end else begin
      if (clr) begin
        m_overrun = 1'b0;
        m_sync    = 1'b0;
      end
      if (p) m_sync = 1'b1;
      if (c && m_active && !e_last) m_overrun = 1'b1;
      if (e_valid) void'(m_q.pop_front());
      if (e_last) m_cnt = m_cnt + 1'b1;
      if (c && (!m_active || e_last)) begin
        m_q.delete();
        for (int k = 0; k < NN; k++) m_q.push_back(xo[k*DW +: DW]);
        m_active = 1'b1;
      end else if (e_last) begin
        m_active = 1'b0;
      end
    end

    @(negedge clk);
  endtask

  initial begin
    logic [NN*DW-1:0] f1;
    logic [NN*DW-1:0] f2;
    logic [NN*DW-1:0] rnd;
    logic [NN-1:0]    ov;
    int               pick;

    compared   = 0;
    mismatched = 0;
    o_valid    = '0;
    x_out      = '0;
    next_ready = 1'b0;
    clear_err  = 1'b0;
    rst        = 1'b1;
    model_reset();

    f1 = pack4(16'h0011, 16'h0022, 16'h0033, 16'h0044);
    f2 = pack4(16'h000A, 16'h000B, 16'h000C, 16'h000D);

    // Initial reset: outputs are unknown before it takes effect, so no checks.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");

    // Reset state
    apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0, "reset_state");

    // Basic frame
    apply_stimulus(4'hF, f1, 1'b1, 1'b0, 1'b0, "basic_cap");
    repeat (5) apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0, "basic");

    // Stall in the middle of a frame
    apply_stimulus(4'hF, f1, 1'b1, 1'b0, 1'b0, "stall_cap");
    apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0, "stall_w0");
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, "stall_hold");
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, "stall_hold");
    repeat (4) apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0, "stall_resume");

    // Back-to-back frames
    apply_stimulus(4'hF, f1, 1'b1, 1'b0, 1'b0, "b2b_cap1");
    repeat (3) apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0, "b2b_first");
    apply_stimulus(4'hF, f2, 1'b1, 1'b0, 1'b0, "b2b_cap2");
    repeat (5) apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0, "b2b_second");

    // Overrun mid-frame, then clear
    apply_stimulus(4'hF, f1, 1'b1, 1'b0, 1'b0, "ovr_cap1");
    apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0, "ovr_w0");
    apply_stimulus(4'hF, f2, 1'b1, 1'b0, 1'b0, "ovr_drop");
    repeat (3) apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0, "ovr_rest");
    apply_stimulus('0, '0, 1'b1, 1'b1, 1'b0, "ovr_clear");
    apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0, "ovr_cleared");

    // Stalled on the final word while a new frame arrives: that is an overrun
    apply_stimulus(4'hF, f2, 1'b1, 1'b0, 1'b0, "ovr_last_cap");
    repeat (3) apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0, "ovr_last_run");
    apply_stimulus(4'hF, f1, 1'b0, 1'b0, 1'b0, "ovr_last_stall");
    repeat (2) apply_stimulus('0, '0, 1'b1, 1'b1, 1'b0, "ovr_last_end");

    // Partial valid, then clear racing with a new partial pattern
    apply_stimulus(4'b0101, f1, 1'b1, 1'b0, 1'b0, "part_set");
    apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0, "part_idle");
    apply_stimulus(4'b0011, f1, 1'b1, 1'b1, 1'b0, "part_clr_race");
    apply_stimulus('0, '0, 1'b1, 1'b1, 1'b0, "part_clr");
    apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0, "part_cleared");

    // Reset in the middle of a frame, then a clean frame
    apply_stimulus(4'hF, f2, 1'b1, 1'b0, 1'b0, "rstmid_cap");
    apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0, "rstmid_w0");
    apply_stimulus('0, '0, 1'b1, 1'b0, 1'b1, "rstmid_rst");
    apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0, "rstmid_after");
    apply_stimulus(4'hF, f1, 1'b1, 1'b0, 1'b0, "rstmid_cap2");
    repeat (5) apply_stimulus('0, '0, 1'b1, 1'b0, 1'b0, "rstmid_frame");

    // Randomized phase
    $display("[TB] random phase");
    for (int i = 0; i < 400; i++) begin
      rnd  = {$urandom(), $urandom()};
      pick = int'($urandom_range(0, 99));
      if (pick < 30)      ov = 4'hF;
      else if (pick < 36) ov = 4'($urandom_range(1, 14));
      else                ov = '0;
      apply_stimulus(ov, rnd, ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 19) == 0), ($urandom_range(0, 79) == 0),
                     "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
